branch_pc_unit: RTL and testbench

Parametrised program-counter and branch-resolution unit for the 16-bit single-cycle CPU. It replaces the combinational branch-offset mux with a registered PC, flag-conditioned branch modes, relative jumps, and a return-address stack for call/return. It sits between instruction decode, which supplies the mode and offset, and instruction memory, which consumes `PC`.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/ret_addr_stack.sv | 49 ++++
 rtl/branch_pc_unit.sv | 92 +++++++++
 tb/tb_branch_pc_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-mode encodings decoded by the PC unit.
package cpu_pkg;

  localparam int BR_MODE_W = 3;

  typedef enum logic [BR_MODE_W-1:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_JMP  = 3'd4,
    BR_CALL = 3'd5,
    BR_RET  = 3'd6,
    BR_RSVD = 3'd7
  } br_mode_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
// A pop on an empty stack is ignored; the caller reports it.
module ret_addr_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign rd_ptr   = wr_ptr - PTR_W'(1);
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage is not reset: count=0 already marks every entry as invalid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= rd_ptr;
      count  <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Registered program counter with flag-conditioned branches, relative jumps
// and a return-address stack for CALL/RET.
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 En,
  input  logic [BR_MODE_W-1:0] Br_Mode,
  input  logic [WIDTH-1:0]     Br_Offset,
  input  logic                 Flag_Z,
  input  logic                 Flag_N,
  output logic [WIDTH-1:0]     PC,
  output logic                 Taken,
  output logic                 Ras_Overflow,
  output logic                 Ras_Underflow
);

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] tgt_pc;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ras_data;
  logic             ras_full;
  logic             ras_empty;
  logic             is_call;
  logic             is_ret;
  logic             taken;
  logic             push;
  logic             pop;

  assign seq_pc = PC + WIDTH'(1);
  assign tgt_pc = seq_pc + Br_Offset;

  always_comb begin
    taken   = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    case (br_mode_e'(Br_Mode))
      BR_BEQ:  taken = Flag_Z;
      BR_BNE:  taken = !Flag_Z;
      BR_BLT:  taken = Flag_N;
      BR_JMP:  taken = 1'b1;
      BR_CALL: begin
        taken   = 1'b1;
        is_call = 1'b1;
      end
      BR_RET: begin
        taken  = !ras_empty;
        is_ret = 1'b1;
      end
      default: taken = 1'b0;
    endcase
  end

  assign push    = En && is_call;
  assign pop     = En && is_ret;
  assign next_pc = !taken ? seq_pc : (is_ret ? ras_data : tgt_pc);

  ret_addr_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .pop_data  (ras_data),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Status outputs are single-cycle and drop to 0 on a stalled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC            <= RESET_PC;
      Taken         <= 1'b0;
      Ras_Overflow  <= 1'b0;
      Ras_Underflow <= 1'b0;
    end else begin
      Taken         <= En && taken;
      Ras_Overflow  <= push && ras_full;
      Ras_Underflow <= pop && ras_empty;
      if (En) PC <= next_pc;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vectors, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_branch_pc_unit;

  localparam int          W      = 16;
  localparam int          D      = 4;
  localparam logic [15:0] RST_PC = 16'h0010;

  localparam logic [2:0] M_NONE = 3'd0;
  localparam logic [2:0] M_BEQ  = 3'd1;
  localparam logic [2:0] M_BNE  = 3'd2;
  localparam logic [2:0] M_BLT  = 3'd3;
  localparam logic [2:0] M_JMP  = 3'd4;
  localparam logic [2:0] M_CALL = 3'd5;
  localparam logic [2:0] M_RET  = 3'd6;
  localparam logic [2:0] M_RSVD = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [W-1:0]  off = '0;
  logic          fz = 1'b0;
  logic          fn = 1'b0;
  logic [W-1:0]  pc;
  logic          taken;
  logic          ovf;
  logic          unf;

  branch_pc_unit #(
    .WIDTH     (W),
    .RAS_DEPTH (D),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .En            (en),
    .Br_Mode       (mode),
    .Br_Offset     (off),
    .Flag_Z        (fz),
    .Flag_N        (fn),
    .PC            (pc),
    .Taken         (taken),
    .Ras_Overflow  (ovf),
    .Ras_Underflow (unf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_pc;
  logic [15:0] m_stk[$];

  typedef struct {
    logic [15:0] start;
    logic [2:0]  md;
    logic [15:0] o;
    logic        z;
    logic        n;
    logic [15:0] exp_pc;
    logic        exp_tk;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: PC arithmetic modulo 2^16, stack as a bounded queue (front = oldest).
  task automatic step(input logic e, input logic [2:0] md, input logic [15:0] o,
                      input logic z, input logic n, input string tag);
    logic [15:0] seq;
    logic [15:0] tgt;
    logic        e_tk;
    logic        e_ov;
    logic        e_un;
    seq  = m_pc + 16'd1;
    tgt  = m_pc + 16'd1 + o;
    e_tk = 1'b0;
    e_ov = 1'b0;
    e_un = 1'b0;
    if (e) begin
      case (md)
        M_BEQ:  e_tk = z;
        M_BNE:  e_tk = !z;
        M_BLT:  e_tk = n;
        M_JMP:  e_tk = 1'b1;
        M_CALL: begin
          e_tk = 1'b1;
          if (m_stk.size() == D) begin
            void'(m_stk.pop_front());
            e_ov = 1'b1;
          end
          m_stk.push_back(seq);
        end
        M_RET: begin
          if (m_stk.size() > 0) e_tk = 1'b1;
          else e_un = 1'b1;
        end
        default: e_tk = 1'b0;
      endcase
      if (!e_tk) m_pc = seq;
      else if (md == M_RET) m_pc = m_stk.pop_back();
      else m_pc = tgt;
    end
    @(negedge clk);
    en = e; mode = md; off = o; fz = z; fn = n;
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
    chk({tag, "_taken"}, 32'(taken), 32'(e_tk));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ov));
    chk({tag, "_unf"}, 32'(unf), 32'(e_un));
  endtask

  task automatic go_to(input logic [15:0] t);
    step(1'b1, M_JMP, t - m_pc - 16'd1, 1'b0, 1'b0, "goto");
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; mode = M_NONE;
    rst_n = 1'b0;
    #1;
    m_pc = RST_PC;
    m_stk.delete();
    chk("rst_pc", 32'(pc), 32'(RST_PC));
    chk("rst_taken", 32'(taken), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_unf", 32'(unf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'h0020, M_BEQ,  16'hFFFB, 1'b1, 1'b0, 16'h001C, 1'b1};
    vecs[1] = '{16'h0020, M_BEQ,  16'hFFFB, 1'b0, 1'b0, 16'h0021, 1'b0};
    vecs[2] = '{16'hFFFF, M_JMP,  16'h0001, 1'b0, 1'b0, 16'h0001, 1'b1};
    vecs[3] = '{16'h0030, M_BNE,  16'h0005, 1'b0, 1'b0, 16'h0036, 1'b1};
    vecs[4] = '{16'h0030, M_BNE,  16'h0005, 1'b1, 1'b0, 16'h0031, 1'b0};
    vecs[5] = '{16'h0030, M_BLT,  16'hFFF0, 1'b0, 1'b1, 16'h0021, 1'b1};
    vecs[6] = '{16'h0030, M_BLT,  16'hFFF0, 1'b1, 1'b0, 16'h0031, 1'b0};
    vecs[7] = '{16'h0030, M_RSVD, 16'h0100, 1'b1, 1'b1, 16'h0031, 1'b0};
    vecs[8] = '{16'h1234, M_NONE, 16'h0100, 1'b1, 1'b1, 16'h1235, 1'b0};

    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, M_NONE, 16'h0000, 1'b0, 1'b0, "seq");
      chk("seq_const", 32'(pc), 32'(16'h0011 + 16'(i)));
    end

    for (int i = 0; i < 9; i++) begin
      go_to(vecs[i].start);
      step(1'b1, vecs[i].md, vecs[i].o, vecs[i].z, vecs[i].n, "vec");
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_taken", i), 32'(taken), 32'(vecs[i].exp_tk));
    end

    // Overflow on the 5th CALL, then four returns and one underflow.
    do_reset();
    go_to(16'h0100);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, M_CALL, 16'h0000, 1'b0, 1'b0, "call");
      chk("call5_ovf", 32'(ovf), 32'(i == 4));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, M_RET, 16'h0000, 1'b0, 1'b0, "ret");
      chk("ret_addr", 32'(pc), 32'(16'h0105 - 16'(i)));
    end
    step(1'b1, M_RET, 16'h0000, 1'b0, 1'b0, "ret_empty");
    chk("ret_empty_unf", 32'(unf), 32'd1);
    chk("ret_empty_pc", 32'(pc), 32'(16'h0103));
    chk("ret_empty_taken", 32'(taken), 32'd0);

    // CALL, stall with stack-modifying inputs present, then RET.
    go_to(16'h0040);
    step(1'b1, M_CALL, 16'h0010, 1'b0, 1'b0, "stall_call");
    chk("stall_call_pc", 32'(pc), 32'(16'h0051));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, (i == 1) ? M_CALL : M_RET, 16'h0007, 1'b1, 1'b1, "stall");
      chk("stall_pc", 32'(pc), 32'(16'h0051));
    end
    step(1'b1, M_RET, 16'h0000, 1'b0, 1'b0, "stall_ret");
    chk("stall_ret_pc", 32'(pc), 32'(16'h0041));
    chk("stall_ret_taken", 32'(taken), 32'd1);

    // Asynchronous reset mid-cycle discards the stack.
    go_to(16'h0200);
    step(1'b1, M_CALL, 16'h0000, 1'b0, 1'b0, "pre_rst_call");
    step(1'b1, M_CALL, 16'h0000, 1'b0, 1'b0, "pre_rst_call");
    #3;
    en = 1'b0; mode = M_NONE;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 32'(pc), 32'(RST_PC));
    chk("async_rst_taken", 32'(taken), 32'd0);
    m_pc = RST_PC;
    m_stk.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, M_RET, 16'h0000, 1'b0, 1'b0, "post_rst_ret");
    chk("post_rst_unf", 32'(unf), 32'd1);
    chk("post_rst_pc", 32'(pc), 32'(16'h0011));

    for (int i = 0; i < 400; i++) begin
      logic [15:0] o;
      o = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15)) - 16'd8;
      step($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), o,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
